// File: rtl/axi_pkg.sv
// Shared AXI encodings, write-responder state type and size limits.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_t;

  localparam int unsigned BUS_DATA_WIDTH = 64;

  // Largest legal awsize for a bus of the given width: log2(bytes per beat).
  function automatic int unsigned max_size(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  localparam int unsigned MAX_SIZE = $clog2(BUS_DATA_WIDTH / 8);

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts.
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            burst,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  output logic [ADDR_WIDTH-1:0] next_addr_c
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  assign step      = ADDR_WIDTH'(1) << size;
  assign incr_addr = addr + step;
  // Wrap boundary is the total burst size (len+1) << size; mask selects the in-window offset.
  assign wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);

  // Select the next address by burst type; reserved encoding holds the address.
  always_comb begin
    next_addr_c = addr;
    case (burst)
      BURST_INCR: next_addr_c = incr_addr;
      BURST_WRAP: next_addr_c = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr_c = addr;
    endcase
  end

endmodule

// File: rtl/axi_write_responder.sv
// AXI write-path subordinate terminator: one burst at a time into the cache write port.
module axi_write_responder
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [1:0]              s_awburst,
  input  logic [2:0]              s_awsize,
  input  logic [7:0]              s_awlen,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic                    mem_wen,
  output logic [ADDR_WIDTH-1:0]   mem_waddr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_wready
);

  localparam int unsigned SIZE_LIMIT = max_size(DATA_WIDTH);

  wr_state_t             state_q;
  wr_state_t             state_d;

  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            burst_q;
  logic [2:0]            size_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic                  err_q;
  logic                  sup_q;

  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic                  cap_err_c;
  logic                  aw_hs_c;
  logic                  beat_c;
  logic                  over_c;
  logic                  short_c;

  assign aw_hs_c    = s_awvalid & s_awready;
  assign beat_c     = s_wvalid & s_wready;
  assign over_c     = cnt_q > len_q;
  assign short_c    = cnt_q < len_q;
  assign align_mask = (ADDR_WIDTH'(1) << s_awsize) - ADDR_WIDTH'(1);

  // Illegal AW parameters detected at capture time.
  always_comb begin
    cap_err_c = 1'b0;
    if (s_awburst == 2'b11) cap_err_c = 1'b1;
    if (32'(s_awsize) > SIZE_LIMIT) cap_err_c = 1'b1;
    if (s_awburst == BURST_WRAP) begin
      if (!(s_awlen == 8'd1 || s_awlen == 8'd3 || s_awlen == 8'd7 || s_awlen == 8'd15))
        cap_err_c = 1'b1;
      if ((s_awaddr & align_mask) != '0) cap_err_c = 1'b1;
    end
  end

  axi_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .addr        (addr_q),
    .burst       (burst_q),
    .size        (size_q),
    .len         (len_q),
    .next_addr_c (next_addr)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; burst end is signalled by wlast alone.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (aw_hs_c)            state_d = ST_DATA;
      ST_DATA: if (beat_c && s_wlast)  state_d = ST_RESP;
      ST_RESP: if (s_bready)           state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; W readiness follows the cache port.
  always_comb begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    case (state_q)
      ST_IDLE: s_awready = 1'b1;
      ST_DATA: s_wready  = mem_wready;
      ST_RESP: s_bvalid  = 1'b1;
      default: s_awready = 1'b0;
    endcase
  end

  // Burst context, beat counter, address and error tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= '0;
      addr_q  <= '0;
      burst_q <= '0;
      size_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      sup_q   <= 1'b0;
    end else if (aw_hs_c) begin
      id_q    <= s_awid;
      addr_q  <= s_awaddr;
      burst_q <= s_awburst;
      size_q  <= s_awsize;
      len_q   <= s_awlen;
      cnt_q   <= '0;
      err_q   <= cap_err_c;
      sup_q   <= cap_err_c;
    end else if (beat_c) begin
      if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
      addr_q <= next_addr;
      if (over_c || (s_wlast && short_c)) err_q <= 1'b1;
    end
  end

  assign mem_wen   = beat_c & ~sup_q & ~over_c;
  assign mem_waddr = addr_q;
  assign mem_wdata = s_wdata;
  assign mem_wstrb = s_wstrb;
  assign s_bid     = id_q;
  assign s_bresp   = err_q ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_write_responder.sv
// Directed self-checking bench for axi_write_responder.
module tb_axi_write_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_awaddr;
  logic [3:0]  s_awid;
  logic [1:0]  s_awburst;
  logic [2:0]  s_awsize;
  logic [7:0]  s_awlen;
  logic        s_awvalid;
  logic        s_awready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wlast;
  logic        s_wvalid;
  logic        s_wready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_wready;

  int vectors     = 0;
  int miscompares = 0;
  int wen_total   = 0;
  int wen_base;

  axi_write_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_awaddr   (s_awaddr),
    .s_awid     (s_awid),
    .s_awburst  (s_awburst),
    .s_awsize   (s_awsize),
    .s_awlen    (s_awlen),
    .s_awvalid  (s_awvalid),
    .s_awready  (s_awready),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_wlast    (s_wlast),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .s_bid      (s_bid),
    .s_bresp    (s_bresp),
    .s_bvalid   (s_bvalid),
    .s_bready   (s_bready),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_wready (mem_wready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write strobes seen at clock edges.
  always @(posedge clk) if (mem_wen) wen_total++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [1:0] burst,
                       input logic [2:0] size, input logic [7:0] len);
    chk("aw_ready", 64'(s_awready), 64'd1);
    s_awvalid = 1'b1;
    s_awid    = id;
    s_awaddr  = addr;
    s_awburst = burst;
    s_awsize  = size;
    s_awlen   = len;
    tick();
    s_awvalid = 1'b0;
    chk("aw_done_ready", 64'(s_awready), 64'd0);
    wen_base = wen_total;
  endtask

  task automatic do_beat(input string tag, input logic last, input logic exp_wen,
                         input logic [31:0] exp_addr);
    s_wvalid = 1'b1;
    s_wlast  = last;
    s_wdata  = {$urandom, $urandom};
    s_wstrb  = 8'($urandom);
    #1;
    chk({tag, "_wready"}, 64'(s_wready), 64'd1);
    chk({tag, "_wen"}, 64'(mem_wen), 64'(exp_wen));
    if (exp_wen) begin
      chk({tag, "_waddr"}, 64'(mem_waddr), 64'(exp_addr));
      chk({tag, "_wdata"}, mem_wdata, s_wdata);
      chk({tag, "_wstrb"}, 64'(mem_wstrb), 64'(s_wstrb));
    end
    tick();
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
  endtask

  task automatic do_resp(input string tag, input logic [3:0] id, input logic [1:0] resp,
                         input int exp_wens);
    chk({tag, "_wen_count"}, 64'(wen_total - wen_base), 64'(exp_wens));
    chk({tag, "_bvalid"}, 64'(s_bvalid), 64'd1);
    chk({tag, "_bid"}, 64'(s_bid), 64'(id));
    chk({tag, "_bresp"}, 64'(s_bresp), 64'(resp));
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk({tag, "_bvalid_clr"}, 64'(s_bvalid), 64'd0);
    chk({tag, "_idle_awready"}, 64'(s_awready), 64'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    s_awaddr   = '0;
    s_awid     = '0;
    s_awburst  = '0;
    s_awsize   = '0;
    s_awlen    = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wlast    = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    mem_wready = 1'b1;
    wen_base   = 0;
    #12;
    chk("rst_awready", 64'(s_awready), 64'd1);
    chk("rst_wready", 64'(s_wready), 64'd0);
    chk("rst_bvalid", 64'(s_bvalid), 64'd0);
    chk("rst_wen", 64'(mem_wen), 64'd0);
    chk("rst_bid", 64'(s_bid), 64'd0);
    chk("rst_bresp", 64'(s_bresp), 64'd0);
    chk("rst_waddr", 64'(mem_waddr), 64'd0);
    rst_n = 1'b1;
    tick();

    // W must not be taken in IDLE.
    s_wvalid = 1'b1;
    #1;
    chk("idle_wready", 64'(s_wready), 64'd0);
    chk("idle_wen", 64'(mem_wen), 64'd0);
    s_wvalid = 1'b0;
    tick();

    // INCR 0x100, 4 beats.
    do_aw(4'h5, 32'h100, 2'b01, 3'd3, 8'd3);
    do_beat("incr_b1", 1'b0, 1'b1, 32'h100);
    do_beat("incr_b2", 1'b0, 1'b1, 32'h108);
    do_beat("incr_b3", 1'b0, 1'b1, 32'h110);
    do_beat("incr_b4", 1'b1, 1'b1, 32'h118);
    do_resp("incr", 4'h5, 2'b00, 4);

    // WRAP 0x118, wraps at 32-byte boundary.
    do_aw(4'h6, 32'h118, 2'b10, 3'd3, 8'd3);
    do_beat("wrap_b1", 1'b0, 1'b1, 32'h118);
    do_beat("wrap_b2", 1'b0, 1'b1, 32'h100);
    do_beat("wrap_b3", 1'b0, 1'b1, 32'h108);
    do_beat("wrap_b4", 1'b1, 1'b1, 32'h110);
    do_resp("wrap", 4'h6, 2'b00, 4);

    // FIXED 0x40, 3 beats.
    do_aw(4'h7, 32'h40, 2'b00, 3'd3, 8'd2);
    do_beat("fixed_b1", 1'b0, 1'b1, 32'h40);
    do_beat("fixed_b2", 1'b0, 1'b1, 32'h40);
    do_beat("fixed_b3", 1'b1, 1'b1, 32'h40);
    do_resp("fixed", 4'h7, 2'b00, 3);

    // Early wlast on beat 2.
    do_aw(4'h8, 32'h300, 2'b01, 3'd3, 8'd3);
    do_beat("short_b1", 1'b0, 1'b1, 32'h300);
    do_beat("short_b2", 1'b1, 1'b1, 32'h308);
    do_resp("short", 4'h8, 2'b10, 2);

    // Late wlast on beat 6: beats 5-6 suppressed.
    do_aw(4'h9, 32'h300, 2'b01, 3'd3, 8'd3);
    do_beat("long_b1", 1'b0, 1'b1, 32'h300);
    do_beat("long_b2", 1'b0, 1'b1, 32'h308);
    do_beat("long_b3", 1'b0, 1'b1, 32'h310);
    do_beat("long_b4", 1'b0, 1'b1, 32'h318);
    do_beat("long_b5", 1'b0, 1'b0, 32'h0);
    do_beat("long_b6", 1'b1, 1'b0, 32'h0);
    do_resp("long", 4'h9, 2'b10, 4);

    // Reserved burst type: beats accepted, nothing written.
    do_aw(4'hA, 32'h80, 2'b11, 3'd3, 8'd1);
    do_beat("rsvd_b1", 1'b0, 1'b0, 32'h0);
    do_beat("rsvd_b2", 1'b1, 1'b0, 32'h0);
    do_resp("rsvd", 4'hA, 2'b10, 0);

    // Oversized beat (size 4 on a 64-bit bus).
    do_aw(4'h3, 32'h0, 2'b01, 3'd4, 8'd0);
    do_beat("size_b1", 1'b1, 1'b0, 32'h0);
    do_resp("size", 4'h3, 2'b10, 0);

    // Misaligned WRAP start.
    do_aw(4'h2, 32'h104, 2'b10, 3'd3, 8'd1);
    do_beat("wmis_b1", 1'b0, 1'b0, 32'h0);
    do_beat("wmis_b2", 1'b1, 1'b0, 32'h0);
    do_resp("wmis", 4'h2, 2'b10, 0);

    // Cache backpressure mid-burst, then B backpressure with a pending AW.
    do_aw(4'hB, 32'h200, 2'b01, 3'd3, 8'd3);
    do_beat("stall_b1", 1'b0, 1'b1, 32'h200);
    s_wvalid   = 1'b1;
    mem_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_wready", 64'(s_wready), 64'd0);
      chk("stall_wen", 64'(mem_wen), 64'd0);
      chk("stall_waddr", 64'(mem_waddr), 64'h208);
      tick();
    end
    s_wvalid   = 1'b0;
    mem_wready = 1'b1;
    do_beat("stall_b2", 1'b0, 1'b1, 32'h208);
    do_beat("stall_b3", 1'b0, 1'b1, 32'h210);
    do_beat("stall_b4", 1'b1, 1'b1, 32'h218);
    s_awvalid = 1'b1;
    s_awid    = 4'h4;
    s_awaddr  = 32'h500;
    s_awburst = 2'b01;
    s_awlen   = 8'd0;
    for (int i = 0; i < 4; i++) begin
      chk("bhold_bvalid", 64'(s_bvalid), 64'd1);
      chk("bhold_bid", 64'(s_bid), 64'hB);
      chk("bhold_bresp", 64'(s_bresp), 64'd0);
      chk("bhold_awready", 64'(s_awready), 64'd0);
      tick();
    end
    s_awvalid = 1'b0;
    do_resp("stall", 4'hB, 2'b00, 4);

    // Reset during DATA abandons the burst.
    do_aw(4'hC, 32'h400, 2'b01, 3'd3, 8'd3);
    do_beat("rst_b1", 1'b0, 1'b1, 32'h400);
    s_wvalid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_awready", 64'(s_awready), 64'd1);
    chk("mid_rst_wready", 64'(s_wready), 64'd0);
    chk("mid_rst_bvalid", 64'(s_bvalid), 64'd0);
    chk("mid_rst_wen", 64'(mem_wen), 64'd0);
    s_wvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_bvalid", 64'(s_bvalid), 64'd0);
    chk("post_rst_awready", 64'(s_awready), 64'd1);

    // Single-beat burst after reset.
    do_aw(4'h1, 32'h10, 2'b01, 3'd2, 8'd0);
    do_beat("single_b1", 1'b1, 1'b1, 32'h10);
    do_resp("single", 4'h1, 2'b00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_write_responder.md
# axi_write_responder

Subordinate-side terminator for the cache's AXI write path. Accepts a write burst on AW/W, tracks beats against `awlen`, and issues per-beat writes to the cache data-array write port with AXI FIXED/INCR/WRAP address generation. Returns one B response per burst, carrying the burst's ID and OKAY/SLVERR. Sits between the AW/W merger output and the cache write port; one burst outstanding at a time.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 64, data width; byte-lane count `DATA_WIDTH/8`
- `ID_WIDTH`, 4, AXI ID width
- Reset is `rst_n`, asynchronous, active-low; clock is `clk`.
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `s_awaddr`/`s_awid`/`s_awburst`/`s_awsize`/`s_awlen`  in  ADDR_WIDTH/ID_WIDTH/2/3/8  AW payload
- `s_awvalid`  in  1; `s_awready`  out  1  AW handshake
- `s_wdata`/`s_wstrb`/`s_wlast`  in  DATA_WIDTH/DATA_WIDTH/8/1  W payload
- `s_wvalid`  in  1; `s_wready`  out  1  W handshake
- `s_bid`/`s_bresp`  out  ID_WIDTH/2  B payload
- `s_bvalid`  out  1; `s_bready`  in  1  B handshake
- `mem_wen`  out  1  one-cycle write strobe per accepted beat
- `mem_waddr`  out  ADDR_WIDTH  beat address
- `mem_wdata`/`mem_wstrb`  out  DATA_WIDTH/DATA_WIDTH/8  beat data and byte enables
- `mem_wready`  in  1  cache able to take a beat this cycle

## Operation
- FSM states: IDLE, DATA, RESP. Reset state is IDLE.
- IDLE: `s_awready`=1. On AW handshake, capture id, addr, burst, size, and len. Clear the beat counter and error flag, then go to DATA.
- Error on capture: burst=2'b11, size > log2(DATA_WIDTH/8), WRAP with len not in {1,3,7,15}, or WRAP with addr not size-aligned. Any of these sets the error flag and suppresses all `mem_wen` for the burst.
- DATA: `s_wready` = `mem_wready`.
  - A beat is accepted when `s_wvalid`&`s_wready`.
  - `mem_wen` = beat accepted & !suppress. `mem_wdata`/`mem_wstrb` pass through combinationally from `s_wdata`/`s_wstrb`. `mem_waddr` = current address register.
- After each accepted beat: counter +1 (saturates at 255), and the address advances.
  - FIXED: unchanged.
  - INCR: addr + (1<<size), modulo 2^ADDR_WIDTH. No 4 KB check; that is the initiator's responsibility.
  - WRAP: with wb = (len+1)<<size, next = (addr & ~(wb-1)) | ((addr + (1<<size)) & (wb-1)).
- Burst end is defined by `s_wlast` only.
  - wlast with counter < len: set error, go to RESP.
  - Counter > len, i.e. beats past awlen: set error and suppress `mem_wen` for those beats. Acceptance continues until wlast.
- RESP: `s_bvalid`=1, `s_bid`=captured id, `s_bresp`=2'b10 (SLVERR) if error else 2'b00 (OKAY). Payload stays stable until `s_bready`. On handshake, go to IDLE.
- Asynchronous reset mid-burst: return to IDLE immediately. Any partial burst is abandoned with no B response.

## Timing
- Reset values:
  - `s_awready`=1 (IDLE).
  - `s_wready`=0, `s_bvalid`=0, `mem_wen`=0.
  - `s_bid`=0, `s_bresp`=0, `mem_waddr`=0.
- AW handshake in cycle N: DATA in N+1. The earliest W beat is accepted in N+1; W is never accepted in IDLE.
- Beat issue latency is 0: `mem_wen` is asserted in the same cycle as the W handshake.
- Last beat accepted in cycle M: `s_bvalid`=1 in M+1.
- B handshake in cycle K: IDLE and `s_awready`=1 in K+1. Minimum AW-to-AW spacing is therefore len+3 cycles.
- `mem_wready` low stalls `s_wready` combinationally. The beat counter and address hold.
- `s_awready` has no combinational dependence on `s_awvalid`. `s_wready` depends only on state and `mem_wready`.

## Structure
- Shared package `axi_pkg`:
  - burst encodings FIXED/INCR/WRAP
  - resp encodings OKAY/SLVERR
  - the `wr_state_t` enum
  - a localparam for the max size, log2(DATA_WIDTH/8)
- Sub-module `axi_addr_gen`: purely combinational next-address calculation from (addr, burst, size, len). The read-path responder reuses it.

## Test plan
- INCR, addr=0x100, size=3, len=3, four beats with wlast on beat 4 -> `mem_waddr` 0x100/0x108/0x110/0x118, four `mem_wen` pulses, B id matches, bresp=OKAY one cycle after the last beat.
- WRAP, addr=0x118, size=3, len=3 -> `mem_waddr` 0x118/0x100/0x108/0x110, bresp=OKAY.
- FIXED, addr=0x40, len=2 -> three writes, all to 0x40, bresp=OKAY.
- INCR, len=3 with wlast on beat 2 -> two writes, B issued after beat 2, bresp=SLVERR. Same burst with wlast on beat 6 -> beats 5-6 accepted with no `mem_wen`, bresp=SLVERR.
- burst=2'b11, len=1 -> both beats accepted, zero `mem_wen`, bresp=SLVERR.
- Hold `mem_wready`=0 for 3 cycles mid-burst, and hold `s_bready`=0 for 4 cycles -> W stalls with address held, `s_bvalid` and its payload stay stable, no AW accepted until after the B handshake. Assert `rst_n` low during DATA -> IDLE, `s_awready`=1, no B issued.
